// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// signature polynomial/seed and the single-step MISR update.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ d;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Controller/DUT-facing bundle of the sweeper: start, truth table, DUT response,
// stimulus vector and result reporting. The sweeper itself uses the slave modport.
interface truth_table_sweeper_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
);
    localparam int N_VEC = 1 << N_IN;

    logic                     start;
    logic [N_VEC*N_OUT-1:0]   exp_table;
    logic [N_OUT-1:0]         dut_out;
    logic [N_IN-1:0]          vec;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [N_IN:0]            err_count;
    logic                     first_fail_valid;
    logic [N_IN-1:0]          first_fail_vec;
    logic [15:0]              sig;

    modport master (
        output start, exp_table, dut_out,
        input  vec, busy, done, pass, err_count, first_fail_valid, first_fail_vec, sig
    );

    modport slave (
        input  start, exp_table, dut_out,
        output vec, busy, done, pass, err_count, first_fail_valid, first_fail_vec, sig
    );
endinterface

// File: rtl/sweep_misr16.sv
// 16-bit multiple-input signature register: seeded on load, folds din in on shift.
module sweep_misr16
    import sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [15:0] din,
    output logic [15:0] sig
);
    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SIG_SEED;
        end else if (shift) begin
            sig_d = misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector, holds each HOLD cycles,
// compares the last-cycle DUT sample against exp_table. SWEEP_SIGNATURE_EN adds a MISR on sig.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int HOLD  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN-1:0]   ffvec_q, ffvec_d;
    logic [N_IN:0]     err_q, err_d;
    logic              ffv_q, ffv_d;
    logic              pass_q, pass_d;

    logic              start_w;
    logic              sample_w;
    logic              mismatch_w;
    logic [N_OUT-1:0]  exp_w;

    assign exp_w      = bus.exp_table[int'(vec_q)*N_OUT +: N_OUT];
    assign start_w    = (state_q == IDLE) && bus.start;
    assign sample_w   = (state_q == APPLY) && (hold_q == HOLD_LAST);
    assign mismatch_w = sample_w && (bus.dut_out != exp_w);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        ffvec_d = ffvec_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start_w) begin
                    state_d = APPLY;
                    hold_d  = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                if (sample_w) begin
                    if (mismatch_w) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    // pass is decided from the count including this last sample
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        vec_d   = '0;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d  = vec_q + N_IN'(1);
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            vec_q   <= '0;
            ffvec_q <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            ffvec_q <= ffvec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec              = vec_q;
    assign bus.busy             = (state_q == APPLY);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;

`ifdef SWEEP_SIGNATURE_EN
    logic [15:0] din_w;

    always_comb begin
        din_w = '0;
        din_w[N_OUT-1:0] = bus.dut_out;
    end

    sweep_misr16 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_w),
        .shift (sample_w),
        .din   (din_w),
        .sig   (bus.sig)
    );
`else
    assign bus.sig = 16'h0000;
`endif
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised self-checking exhaustive stimulus engine for small combinational blocks such as the f-family logic functions. On `start` it drives every input combination 0 … 2^N_IN−1 onto `vec`, holds each for HOLD cycles, and samples the DUT output on the last hold cycle. It compares each sample against a caller-supplied truth table and reports pass/fail, the error count and the first failing vector. It replaces hand-written per-function vector lists and sits between the board/bench controller and the unit under test.

## Interface
- N_IN, 4, number of DUT inputs; legal range 1..8.
- N_OUT, 1, number of DUT outputs; legal range 1..16.
- HOLD, 5, cycles each vector is held; must be ≥1.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- exp_table  in  (2^N_IN)*N_OUT  expected outputs; the entry for vector i is `exp_table[i*N_OUT +: N_OUT]`; must be stable while busy.
- dut_out  in  N_OUT  DUT response to `vec`.
- vec  out  N_IN  stimulus to the DUT.
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  high when the last completed sweep had err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors; cannot overflow.
- first_fail_valid  out  1  at least one mismatch seen this sweep.
- first_fail_vec  out  N_IN  vector index of the first mismatch.
- sig  out  16  output signature; see Configuration.

## Operation
- States:
  - IDLE: vec=0, busy=0; start=1 → APPLY.
  - APPLY: drive vec, count hold_cnt 0..HOLD−1.
  - DONE: done=1 for one cycle, then unconditionally → IDLE.
- On the IDLE→APPLY edge:
  - clear err_count, first_fail_valid, first_fail_vec and pass;
  - set vec=0, hold_cnt=0;
  - load sig with seed.
- In APPLY, at the edge where hold_cnt==HOLD−1, sample dut_out:
  - mismatch with the table entry → err_count+1;
  - if first_fail_valid==0, latch first_fail_vec=vec and set first_fail_valid.
- After sampling:
  - if vec==2^N_IN−1 → DONE, and pass=(final err_count==0);
  - else vec+1, hold_cnt=0.
- err_count, pass and first_fail_* keep their values through DONE/IDLE until the next start.
- start while in APPLY or DONE is ignored; it is not queued.
- Reset at any time, including mid-sweep: immediate return to IDLE; every output reads 0. The next start sweeps from vector 0.

## Timing
- Reset values: vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, sig=0.
- start high at edge E0 → busy=1, vec=0 from E0 onward.
- Each vector is driven for exactly HOLD cycles. The DUT therefore has HOLD−1 full cycles plus one cycle of setup to settle.
- busy stays high for exactly HOLD·2^N_IN cycles.
- done asserts in the cycle immediately after busy falls; busy and done are never high together.
- pass, err_count and first_fail_* are final and stable in the done cycle.
- With HOLD=1, vec advances every cycle and dut_out is sampled in the same cycle vec is applied. This requires a purely combinational DUT path.

## Configuration
- Macro: SWEEP_SIGNATURE_EN.
- Defined:
  - sig is a 16-bit MISR over the sampled outputs, seeded with 16'hFFFF at start.
  - On each sample edge: `sig ← {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended dut_out`.
  - Final value is valid in the done cycle and held until the next start.
- Undefined: sig is tied to 16'h0000, no MISR logic is built, and the port list is unchanged.

## Structure
- Package `sweep_pkg` holds:
  - the state enum (IDLE, APPLY, DONE);
  - SIG_POLY=16'h1021 and SIG_SEED=16'hFFFF.
- Sub-module `sweep_misr16` (clk, rst_n, load, shift, din[15:0], sig[15:0]). It is instantiated only under SWEEP_SIGNATURE_EN.
- The FSM, counters and compare logic stay in the top module.

## Test plan
- N_IN=4, HOLD=5, exp_table=16'hA5C3, bench DUT model = table lookup → busy high exactly 80 cycles, done one cycle later, pass=1, err_count=0, first_fail_valid=0.
- Same setup with the model output inverted only at vector 9 → err_count=1, first_fail_valid=1, first_fail_vec=9, pass=0.
- Model output fully inverted → err_count=16 (5'b10000), first_fail_vec=0, pass=0.
- start pulsed again at busy cycle 20 → ignored; sweep ends at cycle 80 with unchanged results. rst_n low during vector 6 → all outputs 0 immediately; a new start sweeps from vec=0.
- N_IN=2, HOLD=1, N_OUT=2 → vec sequence 0,1,2,3 on consecutive cycles, busy for 4 cycles, compare uses the 2-bit slices.
- With SWEEP_SIGNATURE_EN defined, N_IN=4, N_OUT=1 → sig in the done cycle equals the bench's software MISR from seed 16'hFFFF. Without the macro, sig==0 throughout.
